// File: rtl/interface_tag_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : interface_tag_ctl_if
// Brief    : Request, response and flush channels of the tag controller.
// Revision : 1.0
// ============================================================================
interface interface_tag_ctl_if #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 1024,
    parameter int NSTRMS       = 64,
    parameter int NSTRMS_WIDTH = $clog2(NSTRMS),
    parameter int TAG          = 256,
    parameter int TAG_WIDTH    = $clog2(TAG),
    parameter int L2_NCL       = 256,
    parameter int L2_NCL_WIDTH = $clog2(L2_NCL)
) ();
    logic                    i_req_v;
    logic                    i_req_r;
    logic [NSTRMS_WIDTH-1:0] i_req_sid;
    logic [ADDR_WIDTH-1:0]   i_req_ea;
    logic                    o_req_v;
    logic                    o_req_r;
    logic [ADDR_WIDTH-1:0]   o_req_ea;
    logic [TAG_WIDTH-1:0]    o_req_tag;
    logic                    i_rsp_v;
    logic                    i_rsp_r;
    logic [TAG_WIDTH-1:0]    i_rsp_tag;
    logic [DATA_WIDTH-1:0]   i_rsp_data;
    logic                    o_rsp_v;
    logic                    o_rsp_r;
    logic [DATA_WIDTH-1:0]   o_rsp_data;
    logic [NSTRMS_WIDTH-1:0] o_rsp_sid;
    logic [L2_NCL_WIDTH-1:0] o_rsp_ptr;
    logic                    i_flush_v;
    logic                    i_flush_r;
    logic [TAG_WIDTH:0]      o_free_cnt;
    logic                    o_err;

    modport slave (
        input  i_req_v, i_req_sid, i_req_ea, o_req_r,
        input  i_rsp_v, i_rsp_tag, i_rsp_data, o_rsp_r, i_flush_v,
        output i_req_r, o_req_v, o_req_ea, o_req_tag,
        output i_rsp_r, o_rsp_v, o_rsp_data, o_rsp_sid, o_rsp_ptr,
        output i_flush_r, o_free_cnt, o_err
    );

    modport master (
        output i_req_v, i_req_sid, i_req_ea, o_req_r,
        output i_rsp_v, i_rsp_tag, i_rsp_data, o_rsp_r, i_flush_v,
        input  i_req_r, o_req_v, o_req_ea, o_req_tag,
        input  i_rsp_r, o_rsp_v, o_rsp_data, o_rsp_sid, o_rsp_ptr,
        input  i_flush_r, o_free_cnt, o_err
    );
endinterface
`default_nettype wire

// File: rtl/interface_tag_ctl.sv
`default_nettype none
// ============================================================================
// Module   : interface_tag_ctl
// Brief    : Tag pool issuing request tags and mapping responses to {sid,ptr}.
// Revision : 1.0
// ============================================================================
module interface_tag_ctl #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 1024,
    parameter int NSTRMS       = 64,
    parameter int NSTRMS_WIDTH = $clog2(NSTRMS),
    parameter int TAG          = 256,
    parameter int TAG_WIDTH    = $clog2(TAG),
    parameter int L2_NCL       = 256,
    parameter int L2_NCL_WIDTH = $clog2(L2_NCL),
    parameter int MAX_OUTST    = 16,
    parameter int CNT_WIDTH    = $clog2(MAX_OUTST + 1)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    interface_tag_ctl_if.slave    bus
);
    localparam logic [1:0] c_ST_INIT  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [CNT_WIDTH-1:0] c_MAX_OUTST = CNT_WIDTH'(MAX_OUTST);
    localparam logic [TAG_WIDTH-1:0] c_LAST_TAG  = TAG_WIDTH'(TAG - 1);
    localparam logic [TAG_WIDTH:0]   c_FULL      = (TAG_WIDTH + 1)'(TAG);

    logic [1:0]              r_state;
    logic [TAG_WIDTH-1:0]    r_fifo [TAG];
    logic [TAG_WIDTH-1:0]    r_rd_ptr;
    logic [TAG_WIDTH-1:0]    r_wr_ptr;
    logic [TAG_WIDTH:0]      r_free_cnt;
    logic [NSTRMS_WIDTH-1:0] r_tbl_sid [TAG];
    logic [L2_NCL_WIDTH-1:0] r_tbl_ptr [TAG];
    logic [TAG-1:0]          r_outst;
    logic                    r_req_v;
    logic [ADDR_WIDTH-1:0]   r_req_ea;
    logic [TAG_WIDTH-1:0]    r_req_tag;
    logic                    r_rsp_v;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic [NSTRMS_WIDTH-1:0] r_rsp_sid;
    logic [L2_NCL_WIDTH-1:0] r_rsp_ptr;
    logic                    r_err;

    logic [CNT_WIDTH-1:0]    w_cnt [NSTRMS];
    logic                    w_init, w_req_rdy, w_pop, w_rsp_rdy, w_rsp_acc;
    logic                    w_hit, w_miss, w_push, w_flush_done;
    logic [TAG_WIDTH-1:0]    w_pop_tag, w_push_tag;
    logic [NSTRMS_WIDTH-1:0] w_hit_sid;

    assign w_init    = (r_state == c_ST_INIT);
    assign w_req_rdy = (r_state == c_ST_RUN) && (r_free_cnt != '0) &&
                       (!r_req_v || bus.o_req_r) &&
                       (w_cnt[bus.i_req_sid] < c_MAX_OUTST);
    assign w_pop     = bus.i_req_v && w_req_rdy;
    assign w_pop_tag = r_fifo[r_rd_ptr];
    assign w_rsp_rdy = ((r_state == c_ST_RUN) || (r_state == c_ST_DRAIN)) &&
                       (!r_rsp_v || bus.o_rsp_r);
    assign w_rsp_acc = bus.i_rsp_v && w_rsp_rdy;
    assign w_hit     = w_rsp_acc && r_outst[bus.i_rsp_tag];
    assign w_miss    = w_rsp_acc && !r_outst[bus.i_rsp_tag];
    assign w_hit_sid = r_tbl_sid[bus.i_rsp_tag];
    // During INIT the write pointer doubles as the tag value being seeded.
    assign w_push     = w_init || w_hit;
    assign w_push_tag = w_init ? r_wr_ptr : bus.i_rsp_tag;
    assign w_flush_done = (r_state == c_ST_DRAIN) && (r_free_cnt == c_FULL) && !r_req_v;

    assign bus.i_req_r    = w_req_rdy;
    assign bus.i_rsp_r    = w_rsp_rdy;
    assign bus.i_flush_r  = w_flush_done;
    assign bus.o_req_v    = r_req_v;
    assign bus.o_req_ea   = r_req_ea;
    assign bus.o_req_tag  = r_req_tag;
    assign bus.o_rsp_v    = r_rsp_v;
    assign bus.o_rsp_data = r_rsp_data;
    assign bus.o_rsp_sid  = r_rsp_sid;
    assign bus.o_rsp_ptr  = r_rsp_ptr;
    assign bus.o_free_cnt = r_free_cnt;
    assign bus.o_err      = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_INIT;
        end else begin
            case (r_state)
                c_ST_INIT:  if (r_wr_ptr == c_LAST_TAG) r_state <= c_ST_RUN;
                c_ST_RUN:   if (bus.i_flush_v) r_state <= c_ST_DRAIN;
                c_ST_DRAIN: if (w_flush_done) r_state <= c_ST_RUN;
                default:    r_state <= c_ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_free_cnt <= '0;
        end else begin
            if (w_pop)  r_rd_ptr <= r_rd_ptr + TAG_WIDTH'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + TAG_WIDTH'(1);
            case ({w_push, w_pop})
                2'b10:   r_free_cnt <= r_free_cnt + (TAG_WIDTH + 1)'(1);
                2'b01:   r_free_cnt <= r_free_cnt - (TAG_WIDTH + 1)'(1);
                default: r_free_cnt <= r_free_cnt;
            endcase
        end
    end

    // Storage arrays carry no reset; r_outst qualifies every table read.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_push_tag;
        if (w_pop) begin
            r_tbl_sid[w_pop_tag] <= bus.i_req_sid;
            r_tbl_ptr[w_pop_tag] <= bus.i_req_ea[L2_NCL_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outst <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_pop)  r_outst[w_pop_tag]     <= 1'b1;
            if (w_hit)  r_outst[bus.i_rsp_tag] <= 1'b0;
            if (w_miss) r_err                  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_v    <= 1'b0;
            r_req_ea   <= '0;
            r_req_tag  <= '0;
            r_rsp_v    <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_sid  <= '0;
            r_rsp_ptr  <= '0;
        end else begin
            if (w_pop) begin
                r_req_v   <= 1'b1;
                r_req_ea  <= bus.i_req_ea;
                r_req_tag <= w_pop_tag;
            end else if (bus.o_req_r) begin
                r_req_v   <= 1'b0;
            end
            if (w_hit) begin
                r_rsp_v    <= 1'b1;
                r_rsp_data <= bus.i_rsp_data;
                r_rsp_sid  <= w_hit_sid;
                r_rsp_ptr  <= r_tbl_ptr[bus.i_rsp_tag];
            end else if (bus.o_rsp_r) begin
                r_rsp_v    <= 1'b0;
            end
        end
    end

    for (genvar s = 0; s < NSTRMS; s++) begin : g_cnt
        logic [CNT_WIDTH-1:0] r_cnt;
        logic                 w_inc, w_dec;
        assign w_inc    = w_pop && (bus.i_req_sid == NSTRMS_WIDTH'(s));
        assign w_dec    = w_hit && (w_hit_sid == NSTRMS_WIDTH'(s));
        assign w_cnt[s] = r_cnt;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (w_inc && !w_dec) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end else if (w_dec && !w_inc) begin
                r_cnt <= r_cnt - CNT_WIDTH'(1);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_interface_tag_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_interface_tag_ctl
// Brief    : Directed self-checking bench for interface_tag_ctl (TAG=4, MAX_OUTST=2).
// Revision : 1.0
// ============================================================================
module tb_interface_tag_ctl;
    localparam int ADDR_WIDTH = 64;
    localparam int DATA_WIDTH = 32;
    localparam int NSTRMS     = 4;
    localparam int TAG        = 4;
    localparam int L2_NCL     = 256;
    localparam int MAX_OUTST  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    interface_tag_ctl_if #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NSTRMS(NSTRMS),
        .TAG(TAG), .L2_NCL(L2_NCL)
    ) bus ();

    interface_tag_ctl #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NSTRMS(NSTRMS),
        .TAG(TAG), .L2_NCL(L2_NCL), .MAX_OUTST(MAX_OUTST)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic issue(input logic [1:0] sid, input logic [63:0] ea, input logic [1:0] exp_tag);
        bus.i_req_v   = 1'b1;
        bus.i_req_sid = sid;
        bus.i_req_ea  = ea;
        #1;
        for (int i = 0; i < 20 && bus.i_req_r !== 1'b1; i++) begin
            @(negedge clk); #1;
        end
        check("req_rdy", 64'(bus.i_req_r), 64'd1);
        @(negedge clk);
        bus.i_req_v = 1'b0;
        #1;
        check("req_v",   64'(bus.o_req_v),   64'd1);
        check("req_tag", 64'(bus.o_req_tag), 64'(exp_tag));
        check("req_ea",  bus.o_req_ea,       ea);
    endtask

    task automatic respond(input logic [1:0] tag, input logic [31:0] data);
        bus.i_rsp_v    = 1'b1;
        bus.i_rsp_tag  = tag;
        bus.i_rsp_data = data;
        #1;
        for (int i = 0; i < 20 && bus.i_rsp_r !== 1'b1; i++) begin
            @(negedge clk); #1;
        end
        check("rsp_rdy", 64'(bus.i_rsp_r), 64'd1);
        @(negedge clk);
        bus.i_rsp_v = 1'b0;
        #1;
    endtask

    task automatic check_rsp(input logic [1:0] sid, input logic [7:0] ptr, input logic [31:0] data);
        check("rsp_v",    64'(bus.o_rsp_v),    64'd1);
        check("rsp_sid",  64'(bus.o_rsp_sid),  64'(sid));
        check("rsp_ptr",  64'(bus.o_rsp_ptr),  64'(ptr));
        check("rsp_data", 64'(bus.o_rsp_data), 64'(data));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.i_req_v = 1'b0; bus.i_req_sid = '0; bus.i_req_ea = '0; bus.o_req_r = 1'b1;
        bus.i_rsp_v = 1'b0; bus.i_rsp_tag = '0; bus.i_rsp_data = '0; bus.o_rsp_r = 1'b1;
        bus.i_flush_v = 1'b0;
        #12;
        check("rst_free",    64'(bus.o_free_cnt), 64'd0);
        check("rst_req_v",   64'(bus.o_req_v),    64'd0);
        check("rst_rsp_v",   64'(bus.o_rsp_v),    64'd0);
        check("rst_err",     64'(bus.o_err),      64'd0);
        check("rst_req_r",   64'(bus.i_req_r),    64'd0);
        check("rst_rsp_r",   64'(bus.i_rsp_r),    64'd0);
        check("rst_flush_r", 64'(bus.i_flush_r),  64'd0);

        // Init: request held from reset release, must wait TAG cycles.
        @(negedge clk);
        reset = 1'b0;
        bus.i_req_v = 1'b1; bus.i_req_sid = 2'd3; bus.i_req_ea = 64'h1234;
        #1;
        for (int k = 0; k < TAG; k++) begin
            check("init_req_r", 64'(bus.i_req_r),    64'd0);
            check("init_free",  64'(bus.o_free_cnt), 64'(k));
            @(negedge clk); #1;
        end
        check("init_full", 64'(bus.o_free_cnt), 64'd4);
        issue(2'd3, 64'h1234, 2'd0);
        check("free_after_pop", 64'(bus.o_free_cnt), 64'd3);

        // Mapping back to stream 3 / pointer 0x34.
        respond(2'd0, 32'hAB);
        check_rsp(2'd3, 8'h34, 32'hAB);
        check("free_after_rsp", 64'(bus.o_free_cnt), 64'd4);

        // Per-stream limit: free list order is now 1,2,3,0.
        issue(2'd1, 64'h1A5, 2'd1);
        issue(2'd1, 64'h2B6, 2'd2);
        bus.i_req_v = 1'b1; bus.i_req_sid = 2'd1; bus.i_req_ea = 64'h3C7;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("limit_stall", 64'(bus.i_req_r), 64'd0);
            @(negedge clk); #1;
        end
        respond(2'd1, 32'h11);
        check_rsp(2'd1, 8'hA5, 32'h11);
        check("limit_release", 64'(bus.i_req_r), 64'd1);
        @(negedge clk);
        bus.i_req_v = 1'b0;
        #1;
        check("limit_tag", 64'(bus.o_req_tag), 64'd3);
        check("limit_ea",  bus.o_req_ea,       64'h3C7);
        check("free_two",  64'(bus.o_free_cnt), 64'd2);

        // Illegal return of a free tag.
        respond(2'd0, 32'hEE);
        check("ill_rsp_v", 64'(bus.o_rsp_v),    64'd0);
        check("ill_err",   64'(bus.o_err),      64'd1);
        check("ill_free",  64'(bus.o_free_cnt), 64'd2);
        @(negedge clk); #1;
        check("err_sticky", 64'(bus.o_err), 64'd1);

        // Flush with tags 2,3,0 outstanding.
        issue(2'd2, 64'h4D8, 2'd0);
        bus.i_flush_v = 1'b1;
        @(negedge clk);
        bus.i_req_v = 1'b1; bus.i_req_sid = 2'd2; bus.i_req_ea = 64'h5E9;
        #1;
        check("drain_req_r",  64'(bus.i_req_r),   64'd0);
        check("drain_flush0", 64'(bus.i_flush_r), 64'd0);
        bus.o_rsp_r = 1'b0;
        respond(2'd2, 32'h22);
        check_rsp(2'd1, 8'hB6, 32'h22);
        bus.i_rsp_v = 1'b1; bus.i_rsp_tag = 2'd3; bus.i_rsp_data = 32'h33;
        #1;
        check("rsp_stall1", 64'(bus.i_rsp_r), 64'd0);
        @(negedge clk); #1;
        check("rsp_stall2", 64'(bus.i_rsp_r),    64'd0);
        check("rsp_hold",   64'(bus.o_rsp_data), 64'h22);
        bus.o_rsp_r = 1'b1;
        respond(2'd3, 32'h33);
        check_rsp(2'd1, 8'hC7, 32'h33);
        check("drain_flush1", 64'(bus.i_flush_r), 64'd0);
        respond(2'd0, 32'h44);
        check_rsp(2'd2, 8'hD8, 32'h44);
        check("drain_free",  64'(bus.o_free_cnt), 64'd4);
        check("flush_pulse", 64'(bus.i_flush_r),  64'd1);
        @(negedge clk);
        bus.i_flush_v = 1'b0;
        #1;
        check("flush_once",  64'(bus.i_flush_r), 64'd0);
        check("req_resume",  64'(bus.i_req_r),   64'd1);
        @(negedge clk);
        bus.i_req_v = 1'b0;
        #1;
        check("resume_tag", 64'(bus.o_req_tag), 64'd1);
        check("resume_ea",  bus.o_req_ea,       64'h5E9);

        // Reset with tags 1 and 2 outstanding.
        issue(2'd0, 64'h10, 2'd2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mrst_free",  64'(bus.o_free_cnt), 64'd0);
        check("mrst_err",   64'(bus.o_err),      64'd0);
        check("mrst_req_v", 64'(bus.o_req_v),    64'd0);
        check("mrst_rsp_v", 64'(bus.o_rsp_v),    64'd0);
        check("mrst_req_r", 64'(bus.i_req_r),    64'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.i_req_v = 1'b1; bus.i_req_sid = 2'd0; bus.i_req_ea = 64'h77;
        #1;
        for (int k = 0; k < TAG; k++) begin
            check("reinit_req_r", 64'(bus.i_req_r),    64'd0);
            check("reinit_free",  64'(bus.o_free_cnt), 64'(k));
            @(negedge clk); #1;
        end
        issue(2'd0, 64'h77, 2'd0);
        issue(2'd0, 64'h78, 2'd1);
        check("reinit_err", 64'(bus.o_err), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/interface_tag_ctl.md
Name: interface_tag_ctl

Overview:
Parametrised successor tag interface between the stream cache and the OpenCAPI 3.0 request/response channels. It issues unique tags to outgoing requests and records {sid, ptr} per tag. Returning tagged data is mapped back to its stream and cache-line pointer, and the tag is recycled.
Beyond the previous generation, it adds:
- request blocking until tag-pool initialisation completes;
- per-stream outstanding-request limits;
- detection of illegal or duplicate tag returns;
- a flush handshake that drains all outstanding tags.

Parameters:
addr_width, 64, request effective-address width
data_width, 1024, response data width
nstrms, 64, number of streams
nstrms_width, $clog2(nstrms), stream id width
tag, 256, number of tags in pool (power of 2, >=2)
tag_width, $clog2(tag), tag width
l2_ncl, 256, L2 cache lines per stream
l2_ncl_width, $clog2(l2_ncl), pointer width
max_outst, 16, max outstanding requests per stream (1..tag)
cnt_width, $clog2(max_outst+1), per-stream counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
i_req_v  in  1  request valid
i_req_r  out  1  request ready
i_req_sid  in  nstrms_width  request stream id
i_req_ea  in  addr_width  request effective address
o_req_v  out  1  outgoing request valid
o_req_r  in  1  outgoing request ready
o_req_ea  out  addr_width  outgoing address
o_req_tag  out  tag_width  issued tag
i_rsp_v  in  1  response valid
i_rsp_r  out  1  response ready
i_rsp_tag  in  tag_width  response tag
i_rsp_data  in  data_width  response data
o_rsp_v  out  1  mapped response valid
o_rsp_r  in  1  mapped response ready
o_rsp_data  out  data_width  response data
o_rsp_sid  out  nstrms_width  stream id of tag
o_rsp_ptr  out  l2_ncl_width  i_req_ea[l2_ncl_width-1:0] captured at issue
i_flush_v  in  1  flush request
i_flush_r  out  1  flush complete (handshake)
o_free_cnt  out  tag_width+1  tags currently in free list
o_err  out  1  sticky: response carried a tag not outstanding

Behaviour:
- Reset (asynchronous, active-high) drives the block to state INIT:
  - all outputs are 0;
  - free list empty, per-stream counters 0, outstanding bits 0;
  - o_err cleared.
  A reset mid-operation discards all outstanding state.
- State machine: INIT -> RUN -> DRAIN -> RUN.
- INIT:
  - pushes tags 0,1,...,tag-1 into the free-list FIFO (depth tag), one per cycle;
  - o_free_cnt increments each cycle;
  - i_req_r, i_rsp_r and i_flush_r are 0;
  - moves to RUN in the cycle after tag tag-1 is pushed (tag cycles after reset deassertion).
- RUN, request path:
  - i_req_r = free list non-empty & (~o_req_v | o_req_r) & cnt[i_req_sid] < max_outst;
  - i_req_r may depend on i_req_sid; the source must hold sid and ea stable while valid.
- RUN, request accept:
  - pop the free-list head T;
  - table[T] <= {sid, ea[l2_ncl_width-1:0]}; outst[T] <= 1; cnt[sid]++;
  - register o_req_ea/o_req_tag = ea/T with o_req_v = 1 on the next cycle (1-cycle latency);
  - the output holds until o_req_r.
- Response path (RUN and DRAIN):
  - i_rsp_r = ~o_rsp_v | o_rsp_r;
  - the table has combinational read; o_rsp is registered (1-cycle latency).
- Response accept, tag outstanding (outst[tag] = 1):
  - o_rsp_{data,sid,ptr} loaded from i_rsp_data and table[tag];
  - outst[tag] <= 0; cnt[sid]--; tag pushed to free list.
- Response accept, tag not outstanding:
  - response dropped (no o_rsp_v, no push, no decrement);
  - o_err <= 1, sticky until reset.
- Same-cycle pop and push: o_free_cnt unchanged. The free list cannot overflow because a push requires an outstanding tag.
- Same-cycle increment and decrement of one stream: counter unchanged.
- A tag returned in cycle N may be re-issued no earlier than cycle N+1.
- DRAIN:
  - entered from RUN when i_flush_v = 1; i_req_r = 0; responses still flow;
  - when o_free_cnt == tag & ~o_req_v, asserts i_flush_r for exactly one cycle, then returns to RUN;
  - i_flush_v is held high until i_flush_r;
  - i_flush_v in INIT is ignored until RUN is reached.
- o_free_cnt reflects the registered count: 0 at reset, tag when idle.
- Back-pressure on o_rsp_r stalls i_rsp_r only; request issue continues.

Test Plan:
- Init (tag=4): release reset; i_req_v=1 with sid 0 held -> i_req_r=0 for cycles 0-3; o_free_cnt goes 1,2,3,4; first accept in cycle 4; o_req_tag=0 next cycle.
- Per-stream limit (max_outst=2, tag=4): three sid=1 requests -> tags 0,1 issued, third stalls with i_req_r=0; return tag 0 -> third issues with tag 2 (FIFO order).
- Mapping: request sid=3, ea=0x1234 -> tag 0; respond tag 0 with data 0xAB -> one cycle later o_rsp_sid=3, o_rsp_ptr=0x34 (l2_ncl=256), o_rsp_data=0xAB; o_free_cnt back to 4.
- Illegal return: respond tag 2 while not outstanding -> no o_rsp_v; o_err=1 and stays 1; o_free_cnt unchanged.
- Flush: 3 outstanding tags, assert i_flush_v -> i_req_r=0; return all 3 with o_rsp_r stalled 2 cycles -> i_flush_r pulses once after o_free_cnt=4; requests resume next cycle.
- Reset mid-operation: 2 outstanding, pulse reset -> outputs 0; re-INIT lasts 4 cycles; o_err cleared; counters 0.
